// File: rtl/soc_system_pio_seven_multi.sv
// soc_system_pio_seven_multi
// Avalon-MM slave driving NUM_DIGITS seven-segment digits (active-low segments).
// Per-digit registers, a broadcast write, and a blink engine that blanks
// masked digits on alternate half-periods of BLINK_DIV clock cycles.
// Optional feature macro: SOC_SYSTEM_PIO_SEVEN_HEX_DECODE_EN enables CTRL.DECODE
// (hex-to-segment decode of DIGIT[d][3:0]); without it the block is raw-only.
module soc_system_pio_seven_multi #(
    parameter int               NUM_DIGITS  = 6,
    parameter int               SEG_W       = 7,
    parameter logic [SEG_W-1:0] RESET_VALUE = 7'h7F,
    parameter int               BLINK_DIV   = 25000000
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [3:0]                  address,
    input  logic                        chipselect,
    input  logic                        write_n,
    input  logic [31:0]                 writedata,
    output logic [31:0]                 readdata,
    output logic [NUM_DIGITS*SEG_W-1:0] out_port
);

    localparam int             CNT_W    = $clog2(BLINK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

    logic [SEG_W-1:0]            r_digit [NUM_DIGITS];
    logic                        r_blink_en;
    logic [NUM_DIGITS-1:0]       r_mask;
    logic                        r_phase;
    logic [CNT_W-1:0]            r_cnt;
    logic [NUM_DIGITS*SEG_W-1:0] r_out;

    logic                        w_wr;
    logic                        w_ctrl_wr;
    logic                        w_en_nxt;
    logic                        w_terminal;
    logic                        w_decode;
    logic [SEG_W-1:0]            w_disp [NUM_DIGITS];
    logic [NUM_DIGITS*SEG_W-1:0] w_seg;
    logic [31:0]                 w_rdata;
    logic                        w_unused_ok;

    assign w_wr       = chipselect && !write_n;
    assign w_ctrl_wr  = w_wr && (address == 4'd8);
    // Enable value that will hold after this edge; a CTRL write always governs.
    assign w_en_nxt   = w_ctrl_wr ? writedata[0] : r_blink_en;
    assign w_terminal = (r_cnt == CNT_LAST);
    assign w_unused_ok = ^writedata;

`ifdef SOC_SYSTEM_PIO_SEVEN_HEX_DECODE_EN
    logic r_decode;

    // Active-low hex digit decode, segment order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;  4'h1: seg = 7'h79;  4'h2: seg = 7'h24;  4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;  4'h5: seg = 7'h12;  4'h6: seg = 7'h02;  4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;  4'h9: seg = 7'h10;  4'hA: seg = 7'h08;  4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;  4'hD: seg = 7'h21;  4'hE: seg = 7'h06;  4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    // DECODE bit of CTRL.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_decode <= 1'b0;
        end else if (w_ctrl_wr) begin
            r_decode <= writedata[1];
        end
    end

    assign w_decode = r_decode;

    // Displayed pattern per digit before blanking (decoded or raw).
    always_comb begin
        for (int d = 0; d < NUM_DIGITS; d++) begin
            w_disp[d] = w_decode ? SEG_W'(hex_to_seg(r_digit[d][3:0])) : r_digit[d];
        end
    end
`else
    assign w_decode = 1'b0;

    // Displayed pattern per digit before blanking (raw only).
    always_comb begin
        for (int d = 0; d < NUM_DIGITS; d++) begin
            w_disp[d] = r_digit[d];
        end
    end
`endif

    // Digit registers: individual writes and the broadcast write at address 11.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int d = 0; d < NUM_DIGITS; d++) begin
                r_digit[d] <= RESET_VALUE;
            end
        end else begin
            for (int d = 0; d < NUM_DIGITS; d++) begin
                if (w_wr && ((address == 4'd11) || (address == 4'(d)))) begin
                    r_digit[d] <= writedata[SEG_W-1:0];
                end
            end
        end
    end

    // BLINK_EN bit of CTRL and the BLINK_MASK register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_blink_en <= 1'b0;
            r_mask     <= '0;
        end else begin
            r_blink_en <= w_en_nxt;
            if (w_wr && (address == 4'd9)) begin
                r_mask <= writedata[NUM_DIGITS-1:0];
            end
        end
    end

    // Blink half-period counter and phase; clearing the enable wins over a toggle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (!w_en_nxt) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (r_blink_en) begin
            if (w_terminal) begin
                r_cnt   <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_cnt   <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Segment pattern after blanking of masked digits in the blank phase.
    always_comb begin
        w_seg = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (r_blink_en && r_mask[d] && r_phase) begin
                w_seg[d*SEG_W +: SEG_W] = RESET_VALUE;
            end else begin
                w_seg[d*SEG_W +: SEG_W] = w_disp[d];
            end
        end
    end

    // Registered segment output to the board pins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out <= {NUM_DIGITS{RESET_VALUE}};
        end else begin
            r_out <= w_seg;
        end
    end

    // Zero-wait read mux; unmapped and write-only addresses read as zero.
    always_comb begin
        w_rdata = 32'd0;
        case (address)
            4'd8:    w_rdata = {30'd0, w_decode, r_blink_en};
            4'd9:    w_rdata = {{(32-NUM_DIGITS){1'b0}}, r_mask};
            4'd10:   w_rdata = {31'd0, r_phase};
            default: begin
                for (int d = 0; d < NUM_DIGITS; d++) begin
                    w_rdata = w_rdata | ((address == 4'(d)) ?
                              {{(32-SEG_W){1'b0}}, r_digit[d]} : 32'd0);
                end
            end
        endcase
    end

    assign readdata = w_rdata;
    assign out_port = r_out;

endmodule

// File: tb/tb_soc_system_pio_seven_multi.sv
// Scoreboard bench for soc_system_pio_seven_multi (6 digits, BLINK_DIV = 4).
// The reference model tracks registers plus the number of enabled counting
// edges; the blink phase is derived from that count arithmetically.
module tb_soc_system_pio_seven_multi;

    localparam int ND  = 6;
    localparam int SW  = 7;
    localparam int DIV = 4;
    localparam int OW  = ND * SW;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [3:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic [OW-1:0] out_port;

    soc_system_pio_seven_multi #(
        .NUM_DIGITS (ND),
        .SEG_W      (SW),
        .RESET_VALUE(7'h7F),
        .BLINK_DIV  (DIV)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .out_port  (out_port)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [6:0] m_digit [ND];
    logic       m_en;
    logic       m_dec;
    logic [ND-1:0] m_mask;
    int         m_cnt;          // counting edges since the blink engine was enabled
    logic [OW-1:0] out_cur;     // expected out_port until the next edge

    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Scoreboard
    logic [OW-1:0] q_out [$];
    logic [31:0]   q_rd  [$];
    logic [3:0]    q_addr [$];
    int compared   = 0;
    int mismatched = 0;

    function automatic logic m_phase();
        return ((m_cnt / DIV) % 2) == 1;
    endfunction

    function automatic logic [OW-1:0] m_seg();
        logic [OW-1:0] v;
        logic [6:0] p;
        for (int d = 0; d < ND; d++) begin
            p = m_dec ? hex_tab[m_digit[d][3:0]] : m_digit[d];
            if (m_en && m_mask[d] && m_phase()) p = 7'h7F;
            v[d*SW +: SW] = p;
        end
        return v;
    endfunction

    function automatic logic [31:0] m_read(input logic [3:0] a);
        if (a < 4'(ND)) return {25'd0, m_digit[a]};
        if (a == 4'd8)  return {30'd0, m_dec, m_en};
        if (a == 4'd9)  return {26'd0, m_mask};
        if (a == 4'd10) return {31'd0, m_phase()};
        return 32'd0;
    endfunction

    task automatic m_reset();
        for (int d = 0; d < ND; d++) m_digit[d] = 7'h7F;
        m_en = 1'b0; m_dec = 1'b0; m_mask = '0; m_cnt = 0;
    endtask

    task automatic m_edge(input logic wr, input logic [3:0] a, input logic [31:0] wd);
        logic prev_en;
        prev_en = m_en;
        if (wr) begin
            if (a < 4'(ND)) m_digit[a] = wd[6:0];
            if (a == 4'd11) for (int d = 0; d < ND; d++) m_digit[d] = wd[6:0];
            if (a == 4'd9)  m_mask = wd[ND-1:0];
            if (a == 4'd8) begin
                m_en = wd[0];
`ifdef SOC_SYSTEM_PIO_SEVEN_HEX_DECODE_EN
                m_dec = wd[1];
`endif
            end
        end
        if (!m_en)        m_cnt = 0;
        else if (prev_en) m_cnt = m_cnt + 1;
    endtask

    // One bus cycle: drive inputs just after an edge, queue expectations, take the edge.
    task automatic cycle(input logic cs, input logic wn, input logic [3:0] a, input logic [31:0] wd);
        chipselect = cs; write_n = wn; address = a; writedata = wd;
        q_out.push_back(out_cur);
        q_rd.push_back(m_read(a));
        q_addr.push_back(a);
        @(posedge clk); #1;
        if (!reset_n) begin
            m_reset();
            out_cur = {ND{7'h7F}};
        end else begin
            out_cur = m_seg();
            m_edge(cs && !wn, a, wd);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] wd);
        cycle(1'b1, 1'b0, a, wd);
    endtask

    task automatic rd(input logic [3:0] a);
        cycle(1'b1, 1'b1, a, 32'd0);
    endtask

    // Monitor: compare DUT outputs against the oldest queued expectation.
    initial begin
        logic [OW-1:0] eo;
        logic [31:0]   er;
        logic [3:0]    ea;
        forever begin
            @(negedge clk);
            if (q_out.size() > 0) begin
                eo = q_out.pop_front();
                er = q_rd.pop_front();
                ea = q_addr.pop_front();
                compared++;
                if (out_port !== eo) begin
                    mismatched++;
                    $display("FAIL out_port @%0t: actual %h required %h", $time, out_port, eo);
                end
                compared++;
                if (readdata !== er) begin
                    mismatched++;
                    $display("FAIL readdata addr %0d @%0t: actual %h required %h", ea, $time, readdata, er);
                end
            end
        end
    end

    initial begin
        int guard;
        reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 4'd0; writedata = 32'd0;
        m_reset();
        out_cur = {ND{7'h7F}};
        @(posedge clk); #1;
        rd(4'd0); rd(4'd8);
        reset_n = 1'b1;

        // Reset state
        rd(4'd0); rd(4'd8); rd(4'd10);

        // Single digit write, unmapped address
        wr(4'd2, 32'h0000_0024);
        rd(4'd2); rd(4'd2);
        wr(4'd15, 32'hFFFF_FFFF);
        rd(4'd15);

        // Broadcast
        wr(4'd11, 32'h0000_0012);
        rd(4'd11); rd(4'd0);

        // Blink digits 0-1
        wr(4'd9, 32'h0000_0003);
        wr(4'd8, 32'h0000_0001);
        for (int i = 0; i < 14; i++) rd(4'd10);
        guard = 0;
        while ((m_cnt % DIV) != DIV - 1 && guard < 20) begin
            rd(4'd10);
            guard++;
        end
        wr(4'd8, 32'h0000_0000);          // clear at a counter terminal
        rd(4'd10); rd(4'd8); rd(4'd10);

        // Re-enable, reset mid-blink
        wr(4'd8, 32'h0000_0001);
        for (int i = 0; i < 7; i++) rd(4'd10);
        reset_n = 1'b0;
        m_reset();
        out_cur = {ND{7'h7F}};
        rd(4'd8); rd(4'd9);
        reset_n = 1'b1;
        rd(4'd8); rd(4'd9);

        // Decode mode request (model decides whether it is honoured)
        wr(4'd8, 32'h0000_0002);
        wr(4'd0, 32'h0000_0008);
        rd(4'd0); rd(4'd8); rd(4'd0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic [3:0] a;
            logic [31:0] d;
            a = 4'($urandom_range(0, 15));
            d = $urandom;
            if (a == 4'd8 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
            if ($urandom_range(0, 9) < 3) wr(a, d);
            else if ($urandom_range(0, 1) == 0) rd(a);
            else cycle(1'b0, 1'b0, a, d);
        end

        guard = 0;
        while (q_out.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        if (q_out.size() > 0) begin
            mismatched++;
            $display("FAIL drain: actual %0d pending required 0", q_out.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
